// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, MSB first, all four SPI modes.
// sclk is generated from Pclk by a programmable half-period divider.
//
// Ports:
//   Pclk, Preset         system clock, synchronous active-high reset
//   clk_div              sclk half-period in Pclk cycles (0 behaves as 1)
//   mode                 {CPOL, CPHA}
//   write_data, write_en transmit byte and transfer request
//   enable               must be high to start or continue a transfer
//   miso                 serial input from the slave
//   read_data            last completely received byte
//   cs, mosi, sclk       SPI interface, cs active low
//   pos_edge, neg_edge   one-cycle strobes coincident with the new sclk level
//   busy                 transfer in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cs high, sclk parked at mode[1], waiting for a request
// TRANSFER | cs low, generating 2*DATA_W sclk edges plus a final hold
// DONE     | one cycle: publish received byte, release cs
module spi_master #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 6
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    input  logic              enable,
    input  logic              miso,
    output logic [DATA_W-1:0] read_data,
    output logic              cs,
    output logic              mosi,
    output logic              sclk,
    output logic              pos_edge,
    output logic              neg_edge,
    output logic              busy
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    typedef enum logic [1:0] {IDLE, TRANSFER, DONE} state_t;

    state_t            state_q, state_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              pos_q, pos_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;

    logic [DIV_W-1:0]  div_eff;
    logic              leading;

    assign div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;
    // sclk still at its idle level means the next toggle moves away from CPOL
    assign leading = (sclk_q == cpol_q);

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        rd_d    = rd_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                sclk_d = mode[1];
                if (enable && write_en) begin
                    state_d = TRANSFER;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = write_data[DATA_W-1];
                    tx_d    = write_data;
                    rx_d    = '0;
                    cpol_d  = mode[1];
                    cpha_d  = mode[0];
                    div_d   = div_eff;
                    cnt_d   = div_eff - DIV_W'(1);
                    edge_d  = '0;
                end
            end

            TRANSFER: begin
                if (!enable) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    mosi_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    cnt_d = div_q - DIV_W'(1);
                    if (edge_q == EW'(EDGES)) begin
                        // final half-period hold at CPOL has elapsed
                        state_d = DONE;
                    end else begin
                        edge_d = edge_q + EW'(1);
                        sclk_d = ~sclk_q;
                        pos_d  = ~sclk_q;
                        neg_d  = sclk_q;
                        if (leading) begin
                            if (cpha_q) begin
                                mosi_d = tx_q[DATA_W-1];
                                tx_d   = tx_q << 1;
                            end else begin
                                rx_d = {rx_q[DATA_W-2:0], miso};
                            end
                        end else begin
                            if (cpha_q) begin
                                rx_d = {rx_q[DATA_W-2:0], miso};
                            end else if (edge_q != EW'(EDGES - 1)) begin
                                // bit7 was already presented at cs fall, so
                                // the last trailing edge has nothing to shift
                                mosi_d = tx_q[DATA_W-2];
                                tx_d   = tx_q << 1;
                            end
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
                rd_d    = rx_q;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            div_q   <= DIV_W'(1);
            cnt_q   <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
        end
    end

    assign cs        = cs_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign pos_edge  = pos_q;
    assign neg_edge  = neg_q;
    assign read_data = rd_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, all four modes, clk_div=0,
// busy-time input changes, abort and mid-transfer reset.
module tb_spi_master;

    logic       Pclk = 1'b0;
    logic       Preset = 1'b1;
    logic [5:0] clk_div = 6'd1;
    logic [1:0] mode = 2'd0;
    logic [7:0] write_data = 8'h00;
    logic       write_en = 1'b0;
    logic       enable = 1'b0;
    logic       miso = 1'b0;
    logic [7:0] read_data;
    logic       cs, mosi, sclk, pos_edge, neg_edge, busy;

    int total = 0;
    int bad = 0;

    spi_master #(.DATA_W(8), .DIV_W(6)) dut (
        .Pclk(Pclk), .Preset(Preset), .clk_div(clk_div), .mode(mode),
        .write_data(write_data), .write_en(write_en), .enable(enable),
        .miso(miso), .read_data(read_data), .cs(cs), .mosi(mosi),
        .sclk(sclk), .pos_edge(pos_edge), .neg_edge(neg_edge), .busy(busy)
    );

    always #5 Pclk = ~Pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transfer with a behavioural slave shifting out sb.
    // Request is seen at idx 0; write_data/mode/clk_div are disturbed while busy.
    task automatic xfer(input logic [1:0] m, input logic [5:0] dv, input logic [7:0] wd,
                        input logic [7:0] sb, input logic [7:0] exp_rd);
        int deff, np, nn, first, last, gap_bad, busy_cyc, lat, fall, sidx;
        logic [7:0] cap;
        logic lead_p, trail_p, sample_p;
        deff = (dv == 6'd0) ? 1 : int'(dv);
        np = 0; nn = 0; first = -1; last = 0; gap_bad = 0; busy_cyc = 0;
        lat = -1; fall = -1; sidx = 0; cap = 8'h00;
        @(posedge Pclk); #1;
        mode = m; clk_div = dv; write_en = 1'b0; enable = 1'b1;
        @(posedge Pclk); #1;
        write_data = wd; write_en = 1'b1;
        for (int idx = 0; idx < 3000; idx++) begin
            @(negedge Pclk);
            if (idx == 0) check("idle_sclk", sclk, m[1]);
            if (fall < 0 && cs == 1'b0) begin
                fall = idx;
                if (!m[0]) begin
                    miso = sb[7];
                    sidx = 1;
                end
            end
            if (fall >= 0 && cs == 1'b1) begin
                lat = idx;
                break;
            end
            if (busy) busy_cyc++;
            if (pos_edge || neg_edge) begin
                if (first < 0) first = idx;
                else if (idx - last != deff) gap_bad++;
                last = idx;
            end
            if (pos_edge) np++;
            if (neg_edge) nn++;
            lead_p   = m[1] ? neg_edge : pos_edge;
            trail_p  = m[1] ? pos_edge : neg_edge;
            sample_p = m[0] ? trail_p : lead_p;
            if (sample_p) cap = {cap[6:0], mosi};
            if ((m[0] ? lead_p : trail_p) && sidx < 8) begin
                miso = sb[7 - sidx];
                sidx++;
            end
            if (idx == 1) begin
                write_data = 8'h2E;
                mode = ~m;
                clk_div = dv + 6'd1;
            end
            if (idx == 2) write_data = 8'h43;
            if (idx == 3) begin
                write_en = 1'b0;
                mode = m;
                clk_div = dv;
            end
        end
        check("latency", lat, 17 * deff + 2);
        check("cs_fall", fall, 1);
        check("first_edge", first, 1 + deff);
        check("edge_spacing", gap_bad, 0);
        check("pos_count", np, 8);
        check("neg_count", nn, 8);
        check("busy_cycles", busy_cyc, 17 * deff + 1);
        check("mosi_bits", cap, wd);
        check("read_data", read_data, exp_rd);
        check("end_sclk", sclk, m[1]);
        check("end_busy", busy, 0);
        @(negedge Pclk);
        check("no_restart", {cs, busy}, 2'b10);
    endtask

    initial begin
        int n;
        // reset held with a live request
        Preset = 1'b1; write_en = 1'b1; enable = 1'b1; write_data = 8'h40; mode = 2'd0;
        repeat (3) @(posedge Pclk);
        @(negedge Pclk);
        check("rst_cs", cs, 1);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_read_data", read_data, 8'h00);
        check("rst_edges", {pos_edge, neg_edge}, 2'b00);
        write_en = 1'b0;
        @(posedge Pclk); #1;
        Preset = 1'b0;

        xfer(2'd0, 6'd2, 8'h40, 8'hFF, 8'hFF);
        xfer(2'd3, 6'd2, 8'h80, 8'hFF, 8'hFF);
        xfer(2'd1, 6'd3, 8'h96, 8'hA5, 8'hA5);
        xfer(2'd2, 6'd1, 8'h69, 8'hA5, 8'hA5);
        xfer(2'd0, 6'd0, 8'hC3, 8'h3C, 8'h3C);

        // abort by dropping enable after 3 edges
        @(posedge Pclk); #1;
        mode = 2'd0; clk_div = 6'd2; enable = 1'b1; miso = 1'b1;
        @(posedge Pclk); #1;
        write_data = 8'h5A; write_en = 1'b1;
        n = 0;
        for (int idx = 0; idx < 200; idx++) begin
            @(negedge Pclk);
            if (idx == 1) write_en = 1'b0;
            if (pos_edge || neg_edge) n++;
            if (n == 3) break;
        end
        check("abort_edges", n, 3);
        check("abort_pre_mosi", mosi, 1);
        check("abort_pre_sclk", sclk, 1);
        enable = 1'b0;
        @(negedge Pclk);
        check("abort_cs", cs, 1);
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_read_data", read_data, 8'h3C);

        // reset after 5 edges of a mode 3 transfer
        @(posedge Pclk); #1;
        enable = 1'b1; mode = 2'd3; clk_div = 6'd3;
        @(posedge Pclk); #1;
        write_data = 8'hFF; write_en = 1'b1;
        n = 0;
        for (int idx = 0; idx < 200; idx++) begin
            @(negedge Pclk);
            if (idx == 1) write_en = 1'b0;
            if (pos_edge || neg_edge) n++;
            if (n == 5) break;
        end
        check("reset_edges", n, 5);
        check("reset_pre_mosi", mosi, 1);
        Preset = 1'b1;
        @(negedge Pclk);
        check("mid_rst_cs", cs, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_mosi", mosi, 0);
        check("mid_rst_read_data", read_data, 8'h00);
        check("mid_rst_edges", {pos_edge, neg_edge}, 2'b00);
        @(posedge Pclk); #1;
        Preset = 1'b0;
        repeat (2) @(negedge Pclk);
        check("post_rst_idle", {cs, busy, sclk}, 3'b101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
